// File: rtl/axi_conn_pkg.sv
// Shared constants and default channel/struct types for the AXI connectors.
// The default request/response structs match the connector's default
// parameter widths (ID 8, ADDR 32, DATA 32, user 1).
package axi_conn_pkg;

    // AXI response codes
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    // Fixed AXI4 field widths
    localparam int LEN_W    = 8;
    localparam int SIZE_W   = 3;
    localparam int BURST_W  = 2;
    localparam int CACHE_W  = 4;
    localparam int PROT_W   = 3;
    localparam int QOS_W    = 4;
    localparam int REGION_W = 4;
    localparam int ATOP_W   = 6;

    // Widths of the default struct types
    localparam int DEF_ID_W   = 8;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_USER_W = 1;

    typedef struct packed {
        logic [DEF_ID_W-1:0]   id;
        logic [DEF_ADDR_W-1:0] addr;
        logic [LEN_W-1:0]      len;
        logic [SIZE_W-1:0]     size;
        logic [BURST_W-1:0]    burst;
        logic                  lock;
        logic [CACHE_W-1:0]    cache;
        logic [PROT_W-1:0]     prot;
        logic [QOS_W-1:0]      qos;
        logic [REGION_W-1:0]   region;
        logic [ATOP_W-1:0]     atop;
        logic [DEF_USER_W-1:0] user;
    } aw_chan_def_t;

    typedef struct packed {
        logic [DEF_DATA_W-1:0]   data;
        logic [DEF_DATA_W/8-1:0] strb;
        logic                    last;
        logic [DEF_USER_W-1:0]   user;
    } w_chan_def_t;

    typedef struct packed {
        logic [DEF_ID_W-1:0]   id;
        logic [1:0]            resp;
        logic [DEF_USER_W-1:0] user;
    } b_chan_def_t;

    typedef struct packed {
        logic [DEF_ID_W-1:0]   id;
        logic [DEF_ADDR_W-1:0] addr;
        logic [LEN_W-1:0]      len;
        logic [SIZE_W-1:0]     size;
        logic [BURST_W-1:0]    burst;
        logic                  lock;
        logic [CACHE_W-1:0]    cache;
        logic [PROT_W-1:0]     prot;
        logic [QOS_W-1:0]      qos;
        logic [REGION_W-1:0]   region;
        logic [DEF_USER_W-1:0] user;
    } ar_chan_def_t;

    typedef struct packed {
        logic [DEF_ID_W-1:0]   id;
        logic [DEF_DATA_W-1:0] data;
        logic [1:0]            resp;
        logic                  last;
        logic [DEF_USER_W-1:0] user;
    } r_chan_def_t;

    typedef struct packed {
        aw_chan_def_t aw;
        logic         aw_valid;
        w_chan_def_t  w;
        logic         w_valid;
        logic         b_ready;
        ar_chan_def_t ar;
        logic         ar_valid;
        logic         r_ready;
    } axi_req_def_t;

    typedef struct packed {
        logic        aw_ready;
        logic        ar_ready;
        logic        w_ready;
        logic        b_valid;
        b_chan_def_t b;
        logic        r_valid;
        r_chan_def_t r;
    } axi_rsp_def_t;

endpackage

// File: rtl/axi_conn_skid_buf.sv
// Two-entry skid buffer: registered valid, ready and payload on both sides.
// Output payload always comes from the main register; the skid register only
// absorbs the beat that arrives while the consumer is stalled.
module axi_conn_skid_buf
    import axi_conn_pkg::*;
#(
    parameter type data_t = logic
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  valid_i,
    output logic  ready_o,
    input  data_t data_i,
    output logic  valid_o,
    input  logic  ready_i,
    output data_t data_o
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    logic [1:0] state;
    logic [1:0] state_next;
    logic       ready_q;
    data_t      main_q;
    data_t      skid_q;
    logic       push;
    logic       pop;
    logic       load_main;
    logic       load_skid;
    logic       main_from_skid;

    assign push    = valid_i && ready_q;
    assign pop     = valid_o && ready_i;
    assign valid_o = (state != EMPTY);
    assign ready_o = ready_q;
    assign data_o  = main_q;

    // Next-state and register-load decisions from push/pop
    always_comb begin
        state_next     = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (push) begin
                    state_next = ONE;
                    load_main  = 1'b1;
                end
            end
            ONE: begin
                if (push && !pop) begin
                    state_next = TWO;
                    load_skid  = 1'b1;
                end else if (pop && !push) begin
                    state_next = EMPTY;
                end else if (push && pop) begin
                    load_main = 1'b1;
                end
            end
            TWO: begin
                if (pop) begin
                    state_next     = ONE;
                    main_from_skid = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // Occupancy state and registered upstream ready (low only when both entries are full)
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= EMPTY;
            ready_q <= 1'b0;
        end else begin
            state   <= state_next;
            ready_q <= (state_next != TWO);
        end
    end

    // Payload registers; main reloads from input or drains the skid entry
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main) begin
                main_q <= data_i;
            end else if (main_from_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= data_i;
            end
        end
    end

endmodule

// File: rtl/axi_slave_connector_reg.sv
// Flat AXI4 slave ports to request/response struct pair, with every channel
// cut by a two-entry skid buffer. Optional macro AXI_SLAVE_CONNECTOR_ATOP_EN
// adds s_axi_awatop and carries it through the AW buffer; otherwise atop is 0.
module axi_slave_connector_reg
    import axi_conn_pkg::*;
#(
    parameter int  DATA_WIDTH   = 32,
    parameter int  ADDR_WIDTH   = 32,
    parameter int  STRB_WIDTH   = DATA_WIDTH / 8,
    parameter int  ID_WIDTH     = 8,
    parameter int  AWUSER_WIDTH = 1,
    parameter int  WUSER_WIDTH  = 1,
    parameter int  BUSER_WIDTH  = 1,
    parameter int  ARUSER_WIDTH = 1,
    parameter int  RUSER_WIDTH  = 1,
    parameter type axi_req_t    = axi_req_def_t,
    parameter type axi_rsp_t    = axi_rsp_def_t
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [LEN_W-1:0]        s_axi_awlen,
    input  logic [SIZE_W-1:0]       s_axi_awsize,
    input  logic [BURST_W-1:0]      s_axi_awburst,
    input  logic                    s_axi_awlock,
    input  logic [CACHE_W-1:0]      s_axi_awcache,
    input  logic [PROT_W-1:0]       s_axi_awprot,
    input  logic [QOS_W-1:0]        s_axi_awqos,
    input  logic [REGION_W-1:0]     s_axi_awregion,
`ifdef AXI_SLAVE_CONNECTOR_ATOP_EN
    input  logic [ATOP_W-1:0]       s_axi_awatop,
`endif
    input  logic [AWUSER_WIDTH-1:0] s_axi_awuser,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [STRB_WIDTH-1:0]   s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic [WUSER_WIDTH-1:0]  s_axi_wuser,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic [BUSER_WIDTH-1:0]  s_axi_buser,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [LEN_W-1:0]        s_axi_arlen,
    input  logic [SIZE_W-1:0]       s_axi_arsize,
    input  logic [BURST_W-1:0]      s_axi_arburst,
    input  logic                    s_axi_arlock,
    input  logic [CACHE_W-1:0]      s_axi_arcache,
    input  logic [PROT_W-1:0]       s_axi_arprot,
    input  logic [QOS_W-1:0]        s_axi_arqos,
    input  logic [REGION_W-1:0]     s_axi_arregion,
    input  logic [ARUSER_WIDTH-1:0] s_axi_aruser,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic [RUSER_WIDTH-1:0]  s_axi_ruser,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output axi_req_t                axi_req_o,
    input  axi_rsp_t                axi_resp_i
);

    typedef struct packed {
        logic [ID_WIDTH-1:0]     id;
        logic [ADDR_WIDTH-1:0]   addr;
        logic [LEN_W-1:0]        len;
        logic [SIZE_W-1:0]       size;
        logic [BURST_W-1:0]      burst;
        logic                    lock;
        logic [CACHE_W-1:0]      cache;
        logic [PROT_W-1:0]       prot;
        logic [QOS_W-1:0]        qos;
        logic [REGION_W-1:0]     region;
`ifdef AXI_SLAVE_CONNECTOR_ATOP_EN
        logic [ATOP_W-1:0]       atop;
`endif
        logic [AWUSER_WIDTH-1:0] user;
    } aw_beat_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]  data;
        logic [STRB_WIDTH-1:0]  strb;
        logic                   last;
        logic [WUSER_WIDTH-1:0] user;
    } w_beat_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0]    id;
        logic [1:0]             resp;
        logic [BUSER_WIDTH-1:0] user;
    } b_beat_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0]     id;
        logic [ADDR_WIDTH-1:0]   addr;
        logic [LEN_W-1:0]        len;
        logic [SIZE_W-1:0]       size;
        logic [BURST_W-1:0]      burst;
        logic                    lock;
        logic [CACHE_W-1:0]      cache;
        logic [PROT_W-1:0]       prot;
        logic [QOS_W-1:0]        qos;
        logic [REGION_W-1:0]     region;
        logic [ARUSER_WIDTH-1:0] user;
    } ar_beat_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0]    id;
        logic [DATA_WIDTH-1:0]  data;
        logic [1:0]             resp;
        logic                   last;
        logic [RUSER_WIDTH-1:0] user;
    } r_beat_t;

    aw_beat_t aw_in, aw_out;
    w_beat_t  w_in, w_out;
    b_beat_t  b_in, b_out;
    ar_beat_t ar_in, ar_out;
    r_beat_t  r_in, r_out;
    logic     aw_fab_valid, w_fab_valid, ar_fab_valid;
    logic     b_fab_ready, r_fab_ready;

    // Pack flat forward-channel inputs into buffer words
    always_comb begin
        aw_in.id     = s_axi_awid;
        aw_in.addr   = s_axi_awaddr;
        aw_in.len    = s_axi_awlen;
        aw_in.size   = s_axi_awsize;
        aw_in.burst  = s_axi_awburst;
        aw_in.lock   = s_axi_awlock;
        aw_in.cache  = s_axi_awcache;
        aw_in.prot   = s_axi_awprot;
        aw_in.qos    = s_axi_awqos;
        aw_in.region = s_axi_awregion;
`ifdef AXI_SLAVE_CONNECTOR_ATOP_EN
        aw_in.atop   = s_axi_awatop;
`endif
        aw_in.user   = s_axi_awuser;
        w_in.data    = s_axi_wdata;
        w_in.strb    = s_axi_wstrb;
        w_in.last    = s_axi_wlast;
        w_in.user    = s_axi_wuser;
        ar_in.id     = s_axi_arid;
        ar_in.addr   = s_axi_araddr;
        ar_in.len    = s_axi_arlen;
        ar_in.size   = s_axi_arsize;
        ar_in.burst  = s_axi_arburst;
        ar_in.lock   = s_axi_arlock;
        ar_in.cache  = s_axi_arcache;
        ar_in.prot   = s_axi_arprot;
        ar_in.qos    = s_axi_arqos;
        ar_in.region = s_axi_arregion;
        ar_in.user   = s_axi_aruser;
    end

    // Pack fabric response channels into buffer words
    always_comb begin
        b_in.id   = axi_resp_i.b.id;
        b_in.resp = axi_resp_i.b.resp;
        b_in.user = axi_resp_i.b.user;
        r_in.id   = axi_resp_i.r.id;
        r_in.data = axi_resp_i.r.data;
        r_in.resp = axi_resp_i.r.resp;
        r_in.last = axi_resp_i.r.last;
        r_in.user = axi_resp_i.r.user;
    end

    axi_conn_skid_buf #(.data_t(aw_beat_t)) u_aw_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (s_axi_awvalid),
        .ready_o (s_axi_awready),
        .data_i  (aw_in),
        .valid_o (aw_fab_valid),
        .ready_i (axi_resp_i.aw_ready),
        .data_o  (aw_out)
    );

    axi_conn_skid_buf #(.data_t(w_beat_t)) u_w_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (s_axi_wvalid),
        .ready_o (s_axi_wready),
        .data_i  (w_in),
        .valid_o (w_fab_valid),
        .ready_i (axi_resp_i.w_ready),
        .data_o  (w_out)
    );

    axi_conn_skid_buf #(.data_t(ar_beat_t)) u_ar_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (s_axi_arvalid),
        .ready_o (s_axi_arready),
        .data_i  (ar_in),
        .valid_o (ar_fab_valid),
        .ready_i (axi_resp_i.ar_ready),
        .data_o  (ar_out)
    );

    axi_conn_skid_buf #(.data_t(b_beat_t)) u_b_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (axi_resp_i.b_valid),
        .ready_o (b_fab_ready),
        .data_i  (b_in),
        .valid_o (s_axi_bvalid),
        .ready_i (s_axi_bready),
        .data_o  (b_out)
    );

    axi_conn_skid_buf #(.data_t(r_beat_t)) u_r_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (axi_resp_i.r_valid),
        .ready_o (r_fab_ready),
        .data_i  (r_in),
        .valid_o (s_axi_rvalid),
        .ready_i (s_axi_rready),
        .data_o  (r_out)
    );

    assign s_axi_bid   = b_out.id;
    assign s_axi_bresp = b_out.resp;
    assign s_axi_buser = b_out.user;
    assign s_axi_rid   = r_out.id;
    assign s_axi_rdata = r_out.data;
    assign s_axi_rresp = r_out.resp;
    assign s_axi_rlast = r_out.last;
    assign s_axi_ruser = r_out.user;

    // Unpack buffered forward channels into the fabric request struct
    always_comb begin
        axi_req_o           = '0;
        axi_req_o.aw.id     = aw_out.id;
        axi_req_o.aw.addr   = aw_out.addr;
        axi_req_o.aw.len    = aw_out.len;
        axi_req_o.aw.size   = aw_out.size;
        axi_req_o.aw.burst  = aw_out.burst;
        axi_req_o.aw.lock   = aw_out.lock;
        axi_req_o.aw.cache  = aw_out.cache;
        axi_req_o.aw.prot   = aw_out.prot;
        axi_req_o.aw.qos    = aw_out.qos;
        axi_req_o.aw.region = aw_out.region;
`ifdef AXI_SLAVE_CONNECTOR_ATOP_EN
        axi_req_o.aw.atop   = aw_out.atop;
`else
        axi_req_o.aw.atop   = '0;
`endif
        axi_req_o.aw.user   = aw_out.user;
        axi_req_o.aw_valid  = aw_fab_valid;
        axi_req_o.w.data    = w_out.data;
        axi_req_o.w.strb    = w_out.strb;
        axi_req_o.w.last    = w_out.last;
        axi_req_o.w.user    = w_out.user;
        axi_req_o.w_valid   = w_fab_valid;
        axi_req_o.ar.id     = ar_out.id;
        axi_req_o.ar.addr   = ar_out.addr;
        axi_req_o.ar.len    = ar_out.len;
        axi_req_o.ar.size   = ar_out.size;
        axi_req_o.ar.burst  = ar_out.burst;
        axi_req_o.ar.lock   = ar_out.lock;
        axi_req_o.ar.cache  = ar_out.cache;
        axi_req_o.ar.prot   = ar_out.prot;
        axi_req_o.ar.qos    = ar_out.qos;
        axi_req_o.ar.region = ar_out.region;
        axi_req_o.ar.user   = ar_out.user;
        axi_req_o.ar_valid  = ar_fab_valid;
        axi_req_o.b_ready   = b_fab_ready;
        axi_req_o.r_ready   = r_fab_ready;
    end

endmodule

// File: tb/tb_axi_slave_connector_reg.sv
// Bench for axi_slave_connector_reg: table of single transactions plus
// hand-written burst, backpressure, streaming and reset sequences, with a
// per-channel scoreboard checking order and payload of every beat.
module tb_axi_slave_connector_reg;
    import axi_conn_pkg::*;

`ifdef AXI_SLAVE_CONNECTOR_ATOP_EN
    localparam logic [5:0] EXP_ATOP = 6'h21;
`else
    localparam logic [5:0] EXP_ATOP = 6'h00;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [7:0]  s_axi_awid;   logic [31:0] s_axi_awaddr; logic [7:0] s_axi_awlen;
    logic [2:0]  s_axi_awsize; logic [1:0]  s_axi_awburst; logic s_axi_awlock;
    logic [3:0]  s_axi_awcache; logic [2:0] s_axi_awprot; logic [3:0] s_axi_awqos;
    logic [3:0]  s_axi_awregion; logic [0:0] s_axi_awuser; logic s_axi_awvalid, s_axi_awready;
    logic [5:0]  atop_in;
`ifdef AXI_SLAVE_CONNECTOR_ATOP_EN
    logic [5:0]  s_axi_awatop;
    assign atop_in = s_axi_awatop;
`else
    assign atop_in = 6'h00;
`endif
    logic [31:0] s_axi_wdata; logic [3:0] s_axi_wstrb; logic s_axi_wlast; logic [0:0] s_axi_wuser;
    logic        s_axi_wvalid, s_axi_wready;
    logic [7:0]  s_axi_bid; logic [1:0] s_axi_bresp; logic [0:0] s_axi_buser;
    logic        s_axi_bvalid, s_axi_bready;
    logic [7:0]  s_axi_arid;   logic [31:0] s_axi_araddr; logic [7:0] s_axi_arlen;
    logic [2:0]  s_axi_arsize; logic [1:0]  s_axi_arburst; logic s_axi_arlock;
    logic [3:0]  s_axi_arcache; logic [2:0] s_axi_arprot; logic [3:0] s_axi_arqos;
    logic [3:0]  s_axi_arregion; logic [0:0] s_axi_aruser; logic s_axi_arvalid, s_axi_arready;
    logic [7:0]  s_axi_rid; logic [31:0] s_axi_rdata; logic [1:0] s_axi_rresp;
    logic        s_axi_rlast; logic [0:0] s_axi_ruser; logic s_axi_rvalid, s_axi_rready;
    axi_req_def_t req;
    axi_rsp_def_t rsp;

    axi_slave_connector_reg dut (
        .clk_i(clk), .rst_i(rst),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
        .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot), .s_axi_awqos(s_axi_awqos),
        .s_axi_awregion(s_axi_awregion),
`ifdef AXI_SLAVE_CONNECTOR_ATOP_EN
        .s_axi_awatop(s_axi_awatop),
`endif
        .s_axi_awuser(s_axi_awuser), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wuser(s_axi_wuser), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_buser(s_axi_buser),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
        .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot), .s_axi_arqos(s_axi_arqos),
        .s_axi_arregion(s_axi_arregion), .s_axi_aruser(s_axi_aruser),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_ruser(s_axi_ruser),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .axi_req_o(req), .axi_resp_i(rsp)
    );

    int total = 0;
    int bad   = 0;
    int r_cnt = 0;
    logic [127:0] q_aw[$], q_w[$], q_ar[$], q_b[$], q_r[$];

    typedef struct {
        logic [31:0] addr;  logic [7:0] id;  logic [31:0] wdata; logic [3:0] strb;
        logic [7:0]  bid;   logic [1:0] bresp; logic [5:0] atop;
        logic [31:0] exp_addr; logic [31:0] exp_wdata; logic [3:0] exp_strb;
        logic [7:0]  exp_bid;  logic [1:0]  exp_bresp; logic [5:0] exp_atop;
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_cmp(input string name, input int depth, input logic [127:0] exp,
                          input logic [127:0] act);
        if (depth == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got unexpected beat %0h expected none", name, act);
        end else begin
            check(name, act, exp);
        end
    endtask

    function automatic logic [127:0] pk_aw_in();
        return 128'({s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst,
                     s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awregion,
                     atop_in, s_axi_awuser});
    endfunction
    function automatic logic [127:0] pk_aw_out();
        return 128'({req.aw.id, req.aw.addr, req.aw.len, req.aw.size, req.aw.burst,
                     req.aw.lock, req.aw.cache, req.aw.prot, req.aw.qos, req.aw.region,
                     req.aw.atop, req.aw.user});
    endfunction
    function automatic logic [127:0] pk_ar_in();
        return 128'({s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
                     s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arregion,
                     s_axi_aruser});
    endfunction
    function automatic logic [127:0] pk_ar_out();
        return 128'({req.ar.id, req.ar.addr, req.ar.len, req.ar.size, req.ar.burst,
                     req.ar.lock, req.ar.cache, req.ar.prot, req.ar.qos, req.ar.region,
                     req.ar.user});
    endfunction

    // Scoreboard step, evaluated mid-cycle: compare outputs taken at the next edge,
    // then record inputs accepted at that edge
    task automatic sb_step();
        int n;
        logic [127:0] e;
        if (rst) begin
            q_aw.delete(); q_w.delete(); q_ar.delete(); q_b.delete(); q_r.delete();
            return;
        end
        if (req.aw_valid && rsp.aw_ready) begin
            n = q_aw.size(); e = (n != 0) ? q_aw.pop_front() : 128'd0;
            sb_cmp("sb_aw", n, e, pk_aw_out());
        end
        if (s_axi_awvalid && s_axi_awready) q_aw.push_back(pk_aw_in());
        if (req.w_valid && rsp.w_ready) begin
            n = q_w.size(); e = (n != 0) ? q_w.pop_front() : 128'd0;
            sb_cmp("sb_w", n, e, 128'({req.w.data, req.w.strb, req.w.last, req.w.user}));
        end
        if (s_axi_wvalid && s_axi_wready)
            q_w.push_back(128'({s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wuser}));
        if (req.ar_valid && rsp.ar_ready) begin
            n = q_ar.size(); e = (n != 0) ? q_ar.pop_front() : 128'd0;
            sb_cmp("sb_ar", n, e, pk_ar_out());
        end
        if (s_axi_arvalid && s_axi_arready) q_ar.push_back(pk_ar_in());
        if (s_axi_bvalid && s_axi_bready) begin
            n = q_b.size(); e = (n != 0) ? q_b.pop_front() : 128'd0;
            sb_cmp("sb_b", n, e, 128'({s_axi_bid, s_axi_bresp, s_axi_buser}));
        end
        if (rsp.b_valid && req.b_ready)
            q_b.push_back(128'({rsp.b.id, rsp.b.resp, rsp.b.user}));
        if (s_axi_rvalid && s_axi_rready) begin
            r_cnt++;
            n = q_r.size(); e = (n != 0) ? q_r.pop_front() : 128'd0;
            sb_cmp("sb_r", n, e,
                   128'({s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_ruser}));
        end
        if (rsp.r_valid && req.r_ready)
            q_r.push_back(128'({rsp.r.id, rsp.r.data, rsp.r.resp, rsp.r.last, rsp.r.user}));
    endtask

    // One clock: scoreboard at the falling edge, return 1 time unit after the rising edge
    task automatic tick();
        @(negedge clk);
        sb_step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] readies();
        return {s_axi_awready, s_axi_wready, s_axi_arready, req.b_ready, req.r_ready};
    endfunction
    function automatic logic [4:0] valids();
        return {req.aw_valid, req.w_valid, req.ar_valid, s_axi_bvalid, s_axi_rvalid};
    endfunction

    logic hs;
    logic rv_all;
    int   beat;
    int   r_base;

    initial begin
        vecs[0] = '{32'h0000_1000, 8'h01, 32'hDEAD_BEEF, 4'hF, 8'h05, OKAY,   6'h21,
                    32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 8'h05, OKAY,   EXP_ATOP};
        vecs[1] = '{32'hFFFF_FFFC, 8'hFF, 32'hFFFF_FFFF, 4'h1, 8'hA3, SLVERR, 6'h21,
                    32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'h1, 8'hA3, SLVERR, EXP_ATOP};
        vecs[2] = '{32'h0000_0000, 8'h00, 32'h0000_0000, 4'h0, 8'h00, DECERR, 6'h21,
                    32'h0000_0000, 32'h0000_0000, 4'h0, 8'h00, DECERR, EXP_ATOP};
        vecs[3] = '{32'h1234_5678, 8'h3C, 32'hA5A5_5A5A, 4'hC, 8'h7E, EXOKAY, 6'h21,
                    32'h1234_5678, 32'hA5A5_5A5A, 4'hC, 8'h7E, EXOKAY, EXP_ATOP};

        rst = 1'b1;
        s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0;
        s_axi_awburst = '0; s_axi_awlock = 1'b0; s_axi_awcache = '0; s_axi_awprot = '0;
        s_axi_awqos = '0; s_axi_awregion = '0; s_axi_awuser = '0; s_axi_awvalid = 1'b0;
`ifdef AXI_SLAVE_CONNECTOR_ATOP_EN
        s_axi_awatop = '0;
`endif
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wuser = '0;
        s_axi_wvalid = 1'b0; s_axi_bready = 1'b1;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
        s_axi_arburst = '0; s_axi_arlock = 1'b0; s_axi_arcache = '0; s_axi_arprot = '0;
        s_axi_arqos = '0; s_axi_arregion = '0; s_axi_aruser = '0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b1;
        rsp = '0;
        rsp.aw_ready = 1'b1; rsp.w_ready = 1'b1; rsp.ar_ready = 1'b1;

        // Reset state
        tick(); tick();
        check("rst_readies_low", 128'(readies()), 128'(5'h00));
        check("rst_valids_low", 128'(valids()), 128'(5'h00));
        check("rst_payload_zero", pk_aw_out(), 128'd0);
        rst = 1'b0;
        tick();
        check("post_rst_readies_high", 128'(readies()), 128'(5'h1F));
        check("post_rst_valids_low", 128'(valids()), 128'(5'h00));

        // Table of single transactions on all five channels
        for (int i = 0; i < 4; i++) begin
            s_axi_awvalid = 1'b1; s_axi_awaddr = vecs[i].addr; s_axi_awid = vecs[i].id;
            s_axi_awlen = 8'h00; s_axi_awsize = 3'd2; s_axi_awburst = 2'b01;
            s_axi_awcache = 4'($urandom()); s_axi_awprot = 3'($urandom());
            s_axi_awqos = 4'($urandom()); s_axi_awregion = 4'($urandom());
            s_axi_awlock = 1'($urandom()); s_axi_awuser = 1'($urandom());
`ifdef AXI_SLAVE_CONNECTOR_ATOP_EN
            s_axi_awatop = vecs[i].atop;
`endif
            s_axi_wvalid = 1'b1; s_axi_wdata = vecs[i].wdata; s_axi_wstrb = vecs[i].strb;
            s_axi_wlast = 1'b1; s_axi_wuser = 1'($urandom());
            s_axi_arvalid = 1'b1; s_axi_araddr = vecs[i].addr; s_axi_arid = vecs[i].id;
            s_axi_arcache = 4'($urandom()); s_axi_arqos = 4'($urandom());
            rsp.b_valid = 1'b1; rsp.b.id = vecs[i].bid; rsp.b.resp = vecs[i].bresp;
            rsp.r_valid = 1'b1; rsp.r.data = ~vecs[i].wdata; rsp.r.id = vecs[i].bid;
            rsp.r.last = 1'b1; rsp.r.resp = vecs[i].bresp;
            tick();
            s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
            rsp.b_valid = 1'b0; rsp.r_valid = 1'b0;
            check($sformatf("vec%0d_valids", i), 128'(valids()), 128'(5'h1F));
            check($sformatf("vec%0d_awaddr", i), 128'(req.aw.addr), 128'(vecs[i].exp_addr));
            check($sformatf("vec%0d_atop", i), 128'(req.aw.atop), 128'(vecs[i].exp_atop));
            check($sformatf("vec%0d_w", i), 128'({req.w.data, req.w.strb}),
                  128'({vecs[i].exp_wdata, vecs[i].exp_strb}));
            check($sformatf("vec%0d_araddr", i), 128'(req.ar.addr), 128'(vecs[i].exp_addr));
            check($sformatf("vec%0d_b", i), 128'({s_axi_bid, s_axi_bresp}),
                  128'({vecs[i].exp_bid, vecs[i].exp_bresp}));
            tick();
            check($sformatf("vec%0d_drained", i), 128'(valids()), 128'(5'h00));
        end

        // 16-beat read burst at full throughput
        s_axi_arvalid = 1'b1; s_axi_araddr = 32'h0000_2000; s_axi_arlen = 8'd15; s_axi_arid = 8'h07;
        tick();
        s_axi_arvalid = 1'b0;
        r_base = r_cnt;
        rv_all = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rsp.r_valid = 1'b1; rsp.r.id = 8'h07; rsp.r.data = 32'hA000_0000 + 32'(i);
            rsp.r.resp = OKAY; rsp.r.last = (i == 15);
            tick();
            rv_all = rv_all & s_axi_rvalid;
        end
        rsp.r_valid = 1'b0; rsp.r.last = 1'b0;
        check("burst_rlast_on_16th", 128'({s_axi_rvalid, s_axi_rlast}), 128'(2'b11));
        tick(); tick();
        check("burst_continuous_rvalid", 128'(rv_all), 128'(1'b1));
        check("burst_beat_count", 128'(r_cnt - r_base), 128'(16));

        // R backpressure: consumer stalls 3 cycles while the fabric streams 6 beats
        r_base = r_cnt;
        beat = 0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            rsp.r_valid = (beat < 6); rsp.r.data = 32'hB000_0000 + 32'(beat);
            rsp.r.id = 8'h09; rsp.r.last = (beat == 5);
            s_axi_rready = (cyc >= 3);
            hs = rsp.r_valid && req.r_ready;
            tick();
            if (hs) beat++;
            if (cyc == 1 || cyc == 2) begin
                check($sformatf("bp_ready_low_c%0d", cyc), 128'(req.r_ready), 128'(1'b0));
                check($sformatf("bp_hold_c%0d", cyc), 128'({s_axi_rvalid, s_axi_rdata}),
                      128'({1'b1, 32'hB000_0000}));
            end
        end
        rsp.r_valid = 1'b0; s_axi_rready = 1'b1;
        check("bp_beat_count", 128'(r_cnt - r_base), 128'(6));

        // AW push and pop every cycle in ONE state
        for (int i = 0; i < 10; i++) begin
            s_axi_awvalid = 1'b1; s_axi_awaddr = 32'(i * 4); s_axi_awid = 8'(i);
            tick();
            check($sformatf("aw_stream_%0d", i), 128'({s_axi_awready, req.aw_valid}),
                  128'(2'b11));
        end
        s_axi_awvalid = 1'b0;
        tick(); tick();

        // Reset with two W beats buffered
        rsp.w_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_axi_wvalid = 1'b1; s_axi_wdata = 32'hC000_0000 + 32'(i); s_axi_wlast = (i == 1);
            tick();
        end
        s_axi_wvalid = 1'b0;
        check("w_full_stall", 128'({s_axi_wready, req.w_valid, req.w.data}),
              128'({1'b0, 1'b1, 32'hC000_0000}));
        #2 rst = 1'b1;
        #1;
        check("rst_async_valids", 128'(valids()), 128'(5'h00));
        check("rst_async_readies", 128'(readies()), 128'(5'h00));
        tick();
        rst = 1'b0;
        rsp.w_ready = 1'b1;
        tick();
        check("rst_release_readies", 128'(readies()), 128'(5'h1F));
        tick(); tick(); tick();
        check("rst_nothing_emitted", 128'(valids()), 128'(5'h00));

        check("sb_queues_empty",
              128'(q_aw.size() + q_w.size() + q_ar.size() + q_b.size() + q_r.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
